// File: rtl/varint_encoder_pkg.sv
// Shared definitions for the varint encode path: FSM encoding and
// base-128 group constants.
package varint_encoder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b01,
    EMIT = 2'b10
  } state_e;

  localparam int VARINT_GROUP_BITS = 7;
  localparam int VARINT_CONT_BIT   = 7;
  localparam int VARINT_MAX_BYTES  = 5;

endpackage

// File: rtl/varint_len.sv
// Encoded length of a value as a base-128 varint: the 7-bit group holding
// the highest set bit decides the count; zero still takes one byte.
module varint_len
  import varint_encoder_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic [DATA_WIDTH-1:0] value_i,
  output logic [2:0]            len_o
);

  localparam int NGROUPS = (DATA_WIDTH + VARINT_GROUP_BITS - 1) / VARINT_GROUP_BITS;

  // Later groups overwrite earlier ones, so the highest non-zero group wins.
  always_comb begin
    len_o = 3'd1;
    for (int g = 1; g < NGROUPS; g++) begin
      if (|(value_i >> (VARINT_GROUP_BITS * g))) len_o = 3'(g + 1);
    end
  end

endmodule

// File: rtl/varint_encoder.sv
// Pops 32-bit values from the input FIFO and emits them as protobuf
// varint bytes (LSB group first) into the output FIFO, one byte per cycle.
module varint_encoder
  import varint_encoder_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int INDEX_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   varint_in_fifo_empty,
  input  logic [DATA_WIDTH-1:0]  varint_in_fifo_data,
  input  logic [INDEX_WIDTH-1:0] varint_in_index_data,
  output logic                   varint_in_fifo_pop,
  input  logic                   varint_out_fifo_full,
  output logic                   varint_out_fifo_push,
  output logic [7:0]             varint_out_data,
  output logic [INDEX_WIDTH-1:0] varint_out_index,
  output logic                   varint_out_last,
  input  logic                   encode_clr,
  output logic                   busy,
  output logic [31:0]            value_count
);

  state_e                 state_q;
  logic [DATA_WIDTH-1:0]  shreg_q;
  logic [2:0]             nbytes_q;
  logic [INDEX_WIDTH-1:0] idx_q;
  logic [31:0]            count_q;
  logic [2:0]             len_w;
  logic                   last_w;

  varint_len #(.DATA_WIDTH(DATA_WIDTH)) u_len (
    .value_i (varint_in_fifo_data),
    .len_o   (len_w)
  );

  // Gating with reset/clr keeps handshakes quiet the instant either is seen,
  // so nothing leaks out ahead of the state clearing.
  assign varint_in_fifo_pop   = !reset && !encode_clr && (state_q == IDLE) && !varint_in_fifo_empty;
  assign varint_out_fifo_push = !reset && !encode_clr && (state_q == EMIT) && !varint_out_fifo_full;

  assign last_w           = (nbytes_q == 3'd1);
  assign varint_out_data  = varint_out_fifo_push ? {!last_w, shreg_q[VARINT_GROUP_BITS-1:0]} : 8'h00;
  assign varint_out_index = varint_out_fifo_push ? idx_q : '0;
  assign varint_out_last  = varint_out_fifo_push && last_w;
  assign busy             = (state_q != IDLE);
  assign value_count      = count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      nbytes_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
    end else if (encode_clr) begin
      state_q  <= IDLE;
      shreg_q  <= '0;
      nbytes_q <= '0;
      idx_q    <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (varint_in_fifo_pop) begin
            shreg_q  <= varint_in_fifo_data;
            idx_q    <= varint_in_index_data;
            nbytes_q <= len_w;
            state_q  <= EMIT;
          end
        end
        EMIT: begin
          if (varint_out_fifo_push) begin
            shreg_q  <= shreg_q >> VARINT_GROUP_BITS;
            nbytes_q <= nbytes_q - 3'd1;
            if (last_w) begin
              count_q <= count_q + 32'd1;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

endmodule
